// File: rtl/systolic_output_collector.sv
// Deskews the bottom-row partial_out bytes of the systolic array into whole rows and queues them for a valid/ready consumer.
// Optional build macro COLLECTOR_RELU_EN clamps negative bytes to zero before they enter the FIFO.
module systolic_output_collector #(
  parameter int N     = 4,
  parameter int DEPTH = 4,
  parameter int LAT   = 4
) (
  input  logic           clk,
  input  logic           n_rst,
  input  logic           PE_enable,
  input  logic           start,
  input  logic [7:0]     num_rows,
  input  logic [N*8-1:0] col_in,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N*8-1:0] out_data,
  output logic           out_last,
  output logic           stall,
  output logic           busy,
  output logic           overflow_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int KW = $clog2(LAT + N);
  localparam logic [KW-1:0] K_CAP = KW'(LAT + N - 1);
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_CAPTURE, S_DRAIN} state_t;

  state_t          r_state;
  logic [KW-1:0]   r_k;
  logic [7:0]      r_num;
  logic [7:0]      r_row;
  logic            r_busy;
  logic            r_ovf;

  logic [N*8-1:0]  w_row;
  logic [N*8-1:0]  w_cap_row;
  logic            w_cap;
  logic            w_last;
  logic            w_push;
  logic            w_pop;
  logic            w_full;
  logic            w_drop;
  logic [PW:0]     w_cnt_nxt;

  logic [N*8:0]    r_mem [DEPTH];
  logic [PW-1:0]   r_wr;
  logic [PW-1:0]   r_rd;
  logic [PW:0]     r_cnt;
  logic            r_valid;
  logic            r_stall;

  // Column c is held back N-1-c enabled cycles so all columns of a row line up.
  for (genvar c = 0; c < N; c++) begin : g_col
    if (c == N - 1) begin : g_pass
      assign w_row[8*c +: 8] = col_in[8*c +: 8];
    end else begin : g_dly
      localparam int D = N - 1 - c;
      logic [7:0] r_sr [D];
      always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
          for (int i = 0; i < D; i++) r_sr[i] <= '0;
        end else if (PE_enable) begin
          r_sr[0] <= col_in[8*c +: 8];
          for (int i = 1; i < D; i++) r_sr[i] <= r_sr[i-1];
        end
      end
      assign w_row[8*c +: 8] = r_sr[D-1];
    end
  end

`ifdef COLLECTOR_RELU_EN
  for (genvar b = 0; b < N; b++) begin : g_relu
    assign w_cap_row[8*b +: 8] = w_row[8*b+7] ? 8'h00 : w_row[8*b +: 8];
  end
`else
  assign w_cap_row = w_row;
`endif

  assign w_cap  = PE_enable &&
                  (((r_state == S_FILL) && (r_k == '0)) || (r_state == S_CAPTURE));
  assign w_last = (r_row == (r_num - 8'd1));
  assign w_full = (r_cnt == CNT_FULL);
  assign w_pop  = r_valid && out_ready;
  assign w_push = w_cap && (!w_full || w_pop);
  assign w_drop = w_cap && w_full && !w_pop;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_push && !w_pop)      w_cnt_nxt = r_cnt + (PW+1)'(1);
    else if (!w_push && w_pop) w_cnt_nxt = r_cnt - (PW+1)'(1);
  end

  // r_k is a down-counter: it reaches zero on the enabled cycle that holds aligned row 0.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= S_IDLE;
      r_k     <= '0;
      r_num   <= '0;
      r_row   <= '0;
      r_busy  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start && (num_rows != 8'd0)) begin
            r_state <= S_FILL;
            r_num   <= num_rows;
            r_k     <= K_CAP;
            r_row   <= '0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        S_FILL: begin
          if (PE_enable) begin
            if (r_k == '0) begin
              r_row   <= 8'd1;
              r_state <= (r_num == 8'd1) ? S_DRAIN : S_CAPTURE;
            end else begin
              r_k <= r_k - KW'(1);
            end
          end
        end
        S_CAPTURE: begin
          if (PE_enable) begin
            r_row <= r_row + 8'd1;
            if (w_last) r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (r_cnt == '0) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_drop) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_stall <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= {w_last, w_cap_row};
        r_wr        <= r_wr + PW'(1);
      end
      if (w_pop) r_rd <= r_rd + PW'(1);
      r_cnt   <= w_cnt_nxt;
      r_valid <= (w_cnt_nxt != '0);
      r_stall <= (w_cnt_nxt == CNT_FULL);
    end
  end

  assign out_valid    = r_valid;
  assign out_data     = r_mem[r_rd][N*8-1:0];
  assign out_last     = r_valid && r_mem[r_rd][N*8];
  assign stall        = r_stall;
  assign busy         = r_busy;
  assign overflow_err = r_ovf;

endmodule

// File: doc/systolic_output_collector.md
# systolic_output_collector

Drains and deskews results from the bottom row of the int8 systolic array. Each column's `partial_out` byte arrives one enabled cycle after the column to its left. The collector realigns the columns into whole result rows and buffers them in a small FIFO. It hands rows downstream over a valid/ready handshake and asserts a stall back to the array controller when it cannot accept more rows.

## Interface
- `N`, 4, number of array columns (result bytes per row), ≥2
- `DEPTH`, 4, FIFO depth in rows, power of two, ≥2
- `LAT`, 4, enabled cycles from the first enabled cycle after `start` to column 0 / row 0 on `col_in`
- `clk`  in  1  clock
- `n_rst`  in  1  reset, asynchronous, active-low
- `PE_enable`  in  1  array step strobe; deskew and capture advance only when high
- `start`  in  1  begin a batch; sampled only in IDLE
- `num_rows`  in  8  rows in batch; latched on accepted `start`
- `col_in`  in  N*8  bottom-row `partial_out` bytes; column c at bits [8c+7:8c], signed int8
- `out_valid`  out  1  FIFO head valid
- `out_ready`  in  1  downstream accepts head
- `out_data`  out  N*8  FIFO head row, same column packing as `col_in`
- `out_last`  out  1  head is the final row of its batch
- `stall`  out  1  FIFO full; upstream gates `PE_enable` with `!stall`
- `busy`  out  1  state ≠ IDLE
- `overflow_err`  out  1  sticky: a row was dropped; cleared only by reset or accepted `start`

## Operation
- Reset: all outputs 0; FIFO empty; delay lines 0; state IDLE.
- Deskew: column c passes through an (N-1-c)-stage shift register. Registers shift only when `PE_enable`=1. Column N-1 is undelayed.
- Enabled-cycle index k: k=0 is the first `PE_enable`=1 cycle strictly after the accepted `start` cycle.
  - Column c of row r is on `col_in` at k = LAT + c + r.
  - The aligned row r is therefore present at k = LAT + N-1 + r.
- States:
  - IDLE: `start`=1 and `num_rows`≠0 → FILL. Latches `num_rows`, resets the enable counter, clears `overflow_err`. `start` with `num_rows`=0 is ignored.
  - FILL: counts enabled cycles. At k = LAT+N-1 it captures row 0 and moves to CAPTURE; if `num_rows`=1 it goes directly to DRAIN.
  - CAPTURE: captures one aligned row per enabled cycle. After the capture of row `num_rows`-1 → DRAIN.
  - DRAIN: waits for FIFO empty → IDLE.
- Capture:
  - Pushes the aligned row into the FIFO with its last flag = (r == `num_rows`-1).
  - If the FIFO is full and there is no pop in the same cycle: the row is dropped and `overflow_err` is set. The row counter still advances, so `out_last` tracking stays consistent only if the dropped row is not the last.
- Simultaneous push and pop while full: both occur, no error, count unchanged.
- `start` while `busy`: ignored.
- Cycles with `PE_enable`=0: no shift, no count, no capture; FIFO pops continue.
- Reset mid-batch: immediate return to reset state; in-flight rows discarded.

## Timing
- A row pushed on edge t is visible on `out_data`/`out_valid` after edge t (registered FIFO storage and registered count; no combinational `col_in`→`out_*` path).
- `stall` is a registered decode of count == DEPTH. It is asserted the cycle after the push that fills the FIFO and released the cycle after a pop.
- Pop occurs on an edge with `out_valid`&&`out_ready`. `out_data` must hold stable while `out_valid`=1 and `out_ready`=0.
- `busy` falls on the edge where DRAIN sees an empty FIFO.
- Total latency, accepted `start` → row 0 at the output: LAT+N enabled cycles plus one clock.

## Configuration
- `COLLECTOR_RELU_EN` defined: every captured byte with bit 7 set is replaced by 8'h00 before the FIFO push (ReLU); -128 → 0 and 127 → 127.
- `COLLECTOR_RELU_EN` undefined: bytes are stored unmodified.
- Deskew, FIFO and handshake timing are identical in both builds.

## Test plan
- N=4, LAT=4, `num_rows`=1, `PE_enable` held 1, column c drives 8'h10+c only at k=4+c, `out_ready`=1 → one row 8'h13121110 with `out_last`=1; `busy` low afterward.
- `num_rows`=3, rows skewed per schedule with values r*16+c, `out_ready`=1 → three rows in order; `out_last` only on row 2; no `stall`.
- `out_ready`=0, `num_rows`=6, DEPTH=4, `PE_enable` gated by `!stall` → `stall` rises after the 4th push; no `overflow_err`; releasing `out_ready` delivers all 6 rows in order.
- Same as above but `PE_enable` forced 1 → `overflow_err`=1 after the 5th capture; the FIFO holds rows 0-3.
- `PE_enable` toggled 1,0,0,1,… during FILL → capture indices follow enabled cycles only; the data matches the no-gap run.
- `col_in` bytes 8'h80 and 8'hFF: with `COLLECTOR_RELU_EN` → 8'h00; without → 8'h80 and 8'hFF.
- Reset asserted in CAPTURE → all outputs 0 the same cycle; a subsequent `start` runs cleanly.
